// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional build macro: SEQ_MULT_ADDSHIFT_EN (fused add+shift, fixed latency).
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed for a counter that reaches WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_fsm.sv
// Control FSM for the sequential multiplier: state register, bit counter,
// next-state logic and datapath strobes.
// Optional build macro: SEQ_MULT_ADDSHIFT_EN removes the ADD state and
// performs the conditional add inside SHIFT.
module seq_mult_fsm
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mode,
  input  logic cur_bit,     // multiplier bit currently in B[0]
`ifndef SEQ_MULT_ADDSHIFT_EN
  input  logic next_bit,    // multiplier bit that lands in B[0] on the next edge
`endif
  output logic ld_op,
  output logic add_en,
  output logic sub_en,
  output logic shift_en,
  output logic done,        // final SHIFT: result is registered on this edge
  output logic busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic            last_s;

  assign last_s = (cnt_r == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bit counter: cleared on accept, advanced once per shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (ld_op) begin
      cnt_r <= '0;
    end else if (shift_en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
`ifdef SEQ_MULT_ADDSHIFT_EN
          state_nxt_s = SHIFT;
`else
          state_nxt_s = next_bit ? ADD : SHIFT;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADD: begin
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
`ifdef SEQ_MULT_ADDSHIFT_EN
          state_nxt_s = SHIFT;
`else
          state_nxt_s = next_bit ? ADD : SHIFT;
`endif
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    ld_op    = (state_r == IDLE) && start;
    shift_en = (state_r == SHIFT);
`ifdef SEQ_MULT_ADDSHIFT_EN
    add_en   = (state_r == SHIFT) && cur_bit;
`else
    // ADD is only entered with B[0]=1; qualifying keeps a stray entry harmless.
    add_en   = (state_r == ADD) && cur_bit;
`endif
    // The last multiplier bit carries negative weight in two's complement.
    sub_en   = add_en && mode && last_s;
    done     = (state_r == SHIFT) && last_s;
    busy     = (state_r != IDLE);
  end

endmodule

// File: rtl/seq_mult_ctrl_dp.sv
// Parametrised sequential shift-add multiplier with signed/unsigned mode,
// start/busy/done handshake and registered product. Holds the M, A, B, X
// and Product registers plus the adder/subtractor; control is in seq_mult_fsm.
// Optional build macro: SEQ_MULT_ADDSHIFT_EN (fused add+shift, fixed latency).
module seq_mult_ctrl_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Signed_mode,
  input  logic [WIDTH-1:0]     Mcand,
  input  logic [WIDTH-1:0]     Mplier,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 X_bit
);

  logic [WIDTH-1:0]   m_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               x_r;
  logic               mode_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;

  logic               ld_op_s;
  logic               add_en_s;
  logic               sub_en_s;
  logic               shift_en_s;
  logic               done_s;
  logic               busy_s;

  logic [WIDTH:0]     ext_a_s;
  logic [WIDTH:0]     ext_m_s;
  logic [WIDTH:0]     sum_s;
  logic               pre_x_s;
  logic [WIDTH-1:0]   pre_a_s;
  logic               sh_x_s;
  logic [WIDTH-1:0]   sh_a_s;
  logic [WIDTH-1:0]   sh_b_s;

  seq_mult_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .start    (Start),
    .mode     (mode_r),
    .cur_bit  (b_r[0]),
`ifndef SEQ_MULT_ADDSHIFT_EN
    // In IDLE the next bit is the incoming operand; while busy it is B[1].
    .next_bit (busy_s ? b_r[1] : Mplier[0]),
`endif
    .ld_op    (ld_op_s),
    .add_en   (add_en_s),
    .sub_en   (sub_en_s),
    .shift_en (shift_en_s),
    .done     (done_s),
    .busy     (busy_s)
  );

  // WIDTH+1-bit add/subtract; the extra bit becomes X (sign or carry).
  always_comb begin
    ext_a_s = mode_r ? {a_r[WIDTH-1], a_r} : {1'b0, a_r};
    ext_m_s = mode_r ? {m_r[WIDTH-1], m_r} : {1'b0, m_r};
    if (sub_en_s) begin
      sum_s = ext_a_s - ext_m_s;
    end else begin
      sum_s = ext_a_s + ext_m_s;
    end
  end

  // Right shift of {X,A,B}; arithmetic in signed mode, logical otherwise.
  always_comb begin
`ifdef SEQ_MULT_ADDSHIFT_EN
    if (add_en_s) begin
      pre_x_s = sum_s[WIDTH];
      pre_a_s = sum_s[WIDTH-1:0];
    end else begin
      pre_x_s = x_r;
      pre_a_s = a_r;
    end
`else
    pre_x_s = x_r;
    pre_a_s = a_r;
`endif
    sh_x_s = mode_r ? pre_x_s : 1'b0;
    sh_a_s = {pre_x_s, pre_a_s[WIDTH-1:1]};
    sh_b_s = {pre_a_s[0], b_r[WIDTH-1:1]};
  end

  // Operand capture and {X,A,B} working registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      x_r    <= 1'b0;
      mode_r <= 1'b0;
    end else if (ld_op_s) begin
      m_r    <= Mcand;
      a_r    <= '0;
      b_r    <= Mplier;
      x_r    <= 1'b0;
      mode_r <= Signed_mode;
    end else if (shift_en_s) begin
      x_r    <= sh_x_s;
      a_r    <= sh_a_s;
      b_r    <= sh_b_s;
    end else if (add_en_s) begin
      x_r    <= sum_s[WIDTH];
      a_r    <= sum_s[WIDTH-1:0];
    end else begin
      x_r    <= x_r;
      a_r    <= a_r;
    end
  end

  // Result and Done register on the edge entering DONE so they are valid together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      done_r    <= 1'b0;
      product_r <= '0;
    end else if (done_s) begin
      done_r    <= 1'b1;
      product_r <= {sh_a_s, sh_b_s};
    end else begin
      done_r    <= 1'b0;
      product_r <= product_r;
    end
  end

  assign Busy    = busy_s;
  assign Done    = done_r;
  assign Product = product_r;
  assign X_bit   = x_r;

endmodule

// File: tb/tb_seq_mult_ctrl_dp.sv
// Scoreboard bench for seq_mult_ctrl_dp at WIDTH=8 and WIDTH=16.
module tb_seq_mult_ctrl_dp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s8, md8, busy8, done8, x8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        s16, md16, busy16, done16, x16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp8_q[$];
  int          acc8_q[$];
  int          lat8_q[$];
  logic [31:0] exp16_q[$];
  int          acc16_q[$];
  int          lat16_q[$];

  always #5 clk = ~clk;

  seq_mult_ctrl_dp #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset_n(rst_n), .Start(s8), .Signed_mode(md8),
    .Mcand(a8), .Mplier(b8), .Busy(busy8), .Done(done8),
    .Product(p8), .X_bit(x8)
  );

  seq_mult_ctrl_dp #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset_n(rst_n), .Start(s16), .Signed_mode(md16),
    .Mcand(a16), .Mplier(b16), .Busy(busy16), .Done(done16),
    .Product(p16), .X_bit(x16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare on every Done pulse.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        check("spurious_done8", 64'(done8), 64'd0);
      end else begin
        check("product8", 64'(p8), 64'(exp8_q.pop_front()));
        check("latency8", 64'(cyc - acc8_q.pop_front()), 64'(lat8_q.pop_front()));
      end
    end
    if (done16 === 1'b1) begin
      if (exp16_q.size() == 0) begin
        check("spurious_done16", 64'(done16), 64'd0);
      end else begin
        check("product16", 64'(p16), 64'(exp16_q.pop_front()));
        check("latency16", 64'(cyc - acc16_q.pop_front()), 64'(lat16_q.pop_front()));
      end
    end
  end

  // Drive one accepted operation and push the model result.
  task automatic launch(input bit w16, input bit md, input logic [15:0] mc, input logic [15:0] mp);
    logic signed [15:0] ps8;
    logic        [15:0] pu8;
    logic signed [31:0] ps16;
    logic        [31:0] pu16;
    int                 lat;
    @(negedge clk);
    if (w16) begin
      s16 = 1'b1; md16 = md; a16 = mc; b16 = mp;
    end else begin
      s8 = 1'b1; md8 = md; a8 = mc[7:0]; b8 = mp[7:0];
    end
    @(posedge clk);
    #1;
    if (w16) begin
      ps16 = $signed(mc) * $signed(mp);
      pu16 = mc * mp;
`ifdef SEQ_MULT_ADDSHIFT_EN
      lat = 16;
`else
      lat = 16 + $countones(mp);
`endif
      exp16_q.push_back(md ? ps16 : pu16);
      acc16_q.push_back(cyc);
      lat16_q.push_back(lat);
    end else begin
      ps8 = $signed(mc[7:0]) * $signed(mp[7:0]);
      pu8 = mc[7:0] * mp[7:0];
`ifdef SEQ_MULT_ADDSHIFT_EN
      lat = 8;
`else
      lat = 8 + $countones(mp[7:0]);
`endif
      exp8_q.push_back({16'd0, md ? ps8 : pu8});
      acc8_q.push_back(cyc);
      lat8_q.push_back(lat);
    end
    @(negedge clk);
    s8  = 1'b0;
    s16 = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard for one instance drains.
  task automatic wait_idle(input bit w16);
    int n = 0;
    while (((w16 ? exp16_q.size() : exp8_q.size()) != 0) && (n < 200)) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (w16 ? (exp16_q.size() != 0) : (exp8_q.size() != 0)) begin
      check(w16 ? "timeout16" : "timeout8",
            64'(w16 ? exp16_q.size() : exp8_q.size()), 64'd0);
      exp8_q.delete(); acc8_q.delete(); lat8_q.delete();
      exp16_q.delete(); acc16_q.delete(); lat16_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    s8 = 1'b0; md8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    s16 = 1'b0; md16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    #12;
    check("reset_product8", 64'(p8), 64'd0);
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_x8", 64'(x8), 64'd0);
    check("reset_product16", 64'(p16), 64'd0);
    check("reset_busy16", 64'(busy16), 64'd0);
    check("reset_x16", 64'(x16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    launch(1'b0, 1'b0, 16'h00FF, 16'h00FF);
    check("busy_running8", 64'(busy8), 64'd1);
    wait_idle(1'b0);
    check("hold_ff_ff", 64'(p8), 64'hFE01);
    check("idle_busy8", 64'(busy8), 64'd0);
    launch(1'b0, 1'b1, 16'h0080, 16'h0080);
    wait_idle(1'b0);
    check("signed_m128_sq", 64'(p8), 64'h4000);
    launch(1'b0, 1'b1, 16'h0007, 16'h00FD);
    wait_idle(1'b0);
    check("signed_7_m3", 64'(p8), 64'hFFEB);
    launch(1'b0, 1'b0, 16'h0007, 16'h00FD);
    wait_idle(1'b0);
    check("unsigned_7_253", 64'(p8), 64'h06EB);
    launch(1'b0, 1'b0, 16'h005A, 16'h0000);
    wait_idle(1'b0);
    check("zero_mplier", 64'(p8), 64'h0000);
    launch(1'b1, 1'b1, 16'h7FFF, 16'h8000);
    wait_idle(1'b1);
    check("w16_signed", 64'(p16), 64'hC0008000);

    // Random operands in both modes on both widths.
    for (int i = 0; i < 6; i++) begin
      launch(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
      wait_idle(1'b0);
      launch(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      wait_idle(1'b1);
    end

    // Start while busy must be ignored.
    launch(1'b0, 1'b0, 16'h00FF, 16'h00FF);
    repeat (2) @(negedge clk);
    check("busy_before_restart", 64'(busy8), 64'd1);
    s8 = 1'b1; md8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    s8 = 1'b0;
    wait_idle(1'b0);
    check("restart_ignored", 64'(p8), 64'hFE01);
    repeat (20) @(negedge clk);

    // Reset in the middle of an operation aborts it.
    launch(1'b0, 1'b0, 16'h00C3, 16'h00FF);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_product", 64'(p8), 64'd0);
    exp8_q.delete(); acc8_q.delete(); lat8_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done_product", 64'(p8), 64'd0);
    launch(1'b0, 1'b0, 16'h0003, 16'h0005);
    wait_idle(1'b0);
    check("after_abort_3x5", 64'(p8), 64'h000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
